// File: rtl/csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// csr_trap_ctrl
// ----------------------------------------------------------------------------
// Trap/interrupt sequencer between the interrupt sources, the pipeline and
// the CSR register file.
//
// Behaviour:
//   - Latches timer, external and UART interrupt requests as sticky pending
//     bits and presents them on the CSR file's excep bus.
//   - Picks one winner (ext > uart > timer) among the enabled pending bits.
//   - Sequences trap entry as flush -> drain -> commit, and MRET return as
//     flush -> commit.
//   - Allows only a single trap context at a time; traps never nest.
//
// Parameters:
//   XLEN          - datapath width, matches the CSR file (must be >= 17)
//   DRAIN_TIMEOUT - max cycles in WAIT_DRAIN before a forced commit (2..255)
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-high reset
//   timer_irq    - timer interrupt request (level)
//   ext_irq      - external interrupt request (level)
//   uart_irq     - UART interrupt request (level)
//   mstatus_mie  - global interrupt enable
//   mie_mask     - mie contents; bits 7/11/16 enable timer/ext/uart
//   csr_busy     - CSR instruction in flight; blocks trap start
//   is_mret      - MRET decoded at writeback
//   drain_ack    - pipeline reports drained
//   excep        - pending bits: [7]=timer, [11]=ext, [16]=uart
//   flush_req    - one-cycle pipeline flush request
//   stall_fetch  - hold fetch while sequencing
//   trap_commit  - one-cycle pulse; CSR file takes the trap
//   mret_commit  - one-cycle pulse; CSR file returns to mepc
//   trap_cause   - mcause encoding of the latched winner
//   in_trap      - trap context active
//   drain_to_err - sticky flag, set when a drain timed out
//
// Build option:
//   CSR_IRQ_SYNC_EN - when defined, every irq input goes through a 2-flop
//                     synchronizer before the pending latch, adding two
//                     cycles of latency (minimum irq-to-commit becomes 6).
// ----------------------------------------------------------------------------
module csr_trap_ctrl #(
   parameter int XLEN          = 32,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            timer_irq,
   input  logic            ext_irq,
   input  logic            uart_irq,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mie_mask,
   input  logic            csr_busy,
   input  logic            is_mret,
   input  logic            drain_ack,
   output logic [XLEN-1:0] excep,
   output logic            flush_req,
   output logic            stall_fetch,
   output logic            trap_commit,
   output logic            mret_commit,
   output logic [XLEN-1:0] trap_cause,
   output logic            in_trap,
   output logic            drain_to_err
);

   // Internal source index: [0]=timer, [1]=ext, [2]=uart
   localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-6){1'b0}}, 5'd7};
   localparam logic [XLEN-1:0] CAUSE_EXT   = {1'b1, {(XLEN-6){1'b0}}, 5'd11};
   localparam logic [XLEN-1:0] CAUSE_UART  = {1'b1, {(XLEN-6){1'b0}}, 5'd16};
   localparam logic [7:0]      DRAIN_LAST  = 8'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_WAIT_DRAIN,
      S_COMMIT,
      S_MRET_FLUSH,
      S_MRET_COMMIT
   } state_t;

   state_t            state;
   logic [2:0]        irq_raw;
   logic [2:0]        irq_in;
   logic [2:0]        pending;
   logic [2:0]        eligible;
   logic [2:0]        winner_sel;
   logic [2:0]        winner_q;
   logic [2:0]        pending_clr;
   logic [XLEN-1:0]   cause_sel;
   logic [7:0]        drain_cnt;
   logic              unused_mask_bits;

   assign irq_raw = {uart_irq, ext_irq, timer_irq};

   // Only bits 7/11/16 of mie are meaningful here; the rest are folded into
   // a dummy so their being ignored is explicit.
   assign unused_mask_bits = ^{mie_mask[XLEN-1:17], mie_mask[15:12],
                               mie_mask[10:8], mie_mask[6:0]};

`ifdef CSR_IRQ_SYNC_EN
   logic [2:0] sync_q1;
   logic [2:0] sync_q2;

   // Two-stage synchronizer for requests coming from other clock domains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_raw;
         sync_q2 <= sync_q1;
      end
   end

   assign irq_in = sync_q2;
`else
   assign irq_in = irq_raw;
`endif

   // The latched winner's pending bit drops on the edge that ends COMMIT.
   assign pending_clr = (state == S_COMMIT) ? winner_q : 3'b000;

   // Sticky pending latch. OR-ing the request in after the clear means a
   // request arriving on the same edge as its clear keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~pending_clr) | irq_in;
      end
   end

   // A pending source may start a trap only when individually enabled,
   // globally enabled, and no trap context is already open.
   assign eligible = pending
                   & {mie_mask[16], mie_mask[11], mie_mask[7]}
                   & {3{mstatus_mie & ~in_trap}};

   // Fixed priority: ext > uart > timer.
   always_comb begin
      winner_sel = 3'b000;
      cause_sel  = CAUSE_TIMER;
      if (eligible[1]) begin
         winner_sel = 3'b010;
         cause_sel  = CAUSE_EXT;
      end else if (eligible[2]) begin
         winner_sel = 3'b100;
         cause_sel  = CAUSE_UART;
      end else if (eligible[0]) begin
         winner_sel = 3'b001;
         cause_sel  = CAUSE_TIMER;
      end
   end

   always_comb begin
      excep     = '0;
      excep[7]  = pending[0];
      excep[11] = pending[1];
      excep[16] = pending[2];
   end

   // Sequencer. The pulse/level outputs are registered together with the
   // state they belong to, so each one is asserted exactly while the FSM sits
   // in the matching state. The winner is captured once on IDLE->FLUSH and
   // is not re-evaluated if enables drop later in the sequence.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         winner_q     <= '0;
         trap_cause   <= '0;
         drain_cnt    <= '0;
         in_trap      <= 1'b0;
         drain_to_err <= 1'b0;
         flush_req    <= 1'b0;
         stall_fetch  <= 1'b0;
         trap_commit  <= 1'b0;
         mret_commit  <= 1'b0;
      end else begin
         flush_req   <= 1'b0;
         stall_fetch <= 1'b0;
         trap_commit <= 1'b0;
         mret_commit <= 1'b0;
         case (state)
            S_IDLE: begin
               // A return from an open trap wins over a new interrupt.
               if (is_mret && in_trap) begin
                  state       <= S_MRET_FLUSH;
                  flush_req   <= 1'b1;
                  stall_fetch <= 1'b1;
               end else if ((|eligible) && !csr_busy) begin
                  state       <= S_FLUSH;
                  flush_req   <= 1'b1;
                  stall_fetch <= 1'b1;
                  winner_q    <= winner_sel;
                  trap_cause  <= cause_sel;
               end
            end
            S_FLUSH: begin
               state       <= S_WAIT_DRAIN;
               stall_fetch <= 1'b1;
               drain_cnt   <= '0;
            end
            S_WAIT_DRAIN: begin
               stall_fetch <= 1'b1;
               if (drain_ack) begin
                  state       <= S_COMMIT;
                  trap_commit <= 1'b1;
               end else if (drain_cnt == DRAIN_LAST) begin
                  // Pipeline never acknowledged: commit anyway, flag it.
                  state        <= S_COMMIT;
                  trap_commit  <= 1'b1;
                  drain_to_err <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            S_COMMIT: begin
               state   <= S_IDLE;
               in_trap <= 1'b1;
            end
            S_MRET_FLUSH: begin
               state       <= S_MRET_COMMIT;
               mret_commit <= 1'b1;
            end
            S_MRET_COMMIT: begin
               state   <= S_IDLE;
               in_trap <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csr_trap_ctrl
// ----------------------------------------------------------------------------
// Directed bench for csr_trap_ctrl. Every commit pulse the stimulus expects
// is pushed into a scoreboard queue; a monitor process pops one entry per
// trap_commit/mret_commit pulse and compares kind, cause and error flag.
// Cycle-accurate checks of the control outputs are made inline by the
// stimulus at hand-computed cycles.
// ----------------------------------------------------------------------------
module tb_csr_trap_ctrl;

   localparam int XLEN = 32;
   localparam int DRAIN_TIMEOUT = 16;

   typedef struct packed {
      logic        is_mret;
      logic [31:0] cause;
      logic        err;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            timer_irq;
   logic            ext_irq;
   logic            uart_irq;
   logic            mstatus_mie;
   logic [XLEN-1:0] mie_mask;
   logic            csr_busy;
   logic            is_mret;
   logic            drain_ack;
   logic [XLEN-1:0] excep;
   logic            flush_req;
   logic            stall_fetch;
   logic            trap_commit;
   logic            mret_commit;
   logic [XLEN-1:0] trap_cause;
   logic            in_trap;
   logic            drain_to_err;

   exp_t sb[$];
   int   compared;
   int   mismatched;

   csr_trap_ctrl #(
      .XLEN          (XLEN),
      .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .timer_irq    (timer_irq),
      .ext_irq      (ext_irq),
      .uart_irq     (uart_irq),
      .mstatus_mie  (mstatus_mie),
      .mie_mask     (mie_mask),
      .csr_busy     (csr_busy),
      .is_mret      (is_mret),
      .drain_ack    (drain_ack),
      .excep        (excep),
      .flush_req    (flush_req),
      .stall_fetch  (stall_fetch),
      .trap_commit  (trap_commit),
      .mret_commit  (mret_commit),
      .trap_cause   (trap_cause),
      .in_trap      (in_trap),
      .drain_to_err (drain_to_err)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls the stimulus
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // {flush_req, stall_fetch, trap_commit, mret_commit, in_trap, drain_to_err}
   function automatic logic [31:0] ctrlBits();
      return {26'b0, flush_req, stall_fetch, trap_commit, mret_commit,
              in_trap, drain_to_err};
   endfunction

   function automatic exp_t mkExp(input logic m, input logic [31:0] c,
                                  input logic e);
      exp_t x;
      x.is_mret = m;
      x.cause   = c;
      x.err     = e;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual,
                  expected);
      end
   endtask

   task automatic applyStimulus(input logic t, input logic e, input logic u,
                                input logic m);
      timer_irq = t;
      ext_irq   = e;
      uart_irq  = u;
      is_mret   = m;
   endtask

   // Advance to one time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From IDLE with a trap open: MRET_FLUSH, MRET_COMMIT, then back in IDLE
   task automatic runMret();
      is_mret = 1'b1;
      tick();
      is_mret = 1'b0;
      tick();
      tick();
   endtask

   // Scoreboard monitor: one queue entry per commit pulse
   task automatic monitorLoop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (trap_commit || mret_commit)) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL sb_unexpected: got trap_commit=%0b mret_commit=%0b, expected no pulse",
                        trap_commit, mret_commit);
            end else begin
               e = sb.pop_front();
               checkOutput("sb_kind", {30'b0, mret_commit, trap_commit},
                           e.is_mret ? 32'h2 : 32'h1);
               if (!e.is_mret)
                  checkOutput("sb_cause", trap_cause, e.cause);
               checkOutput("sb_err", {31'b0, drain_to_err}, {31'b0, e.err});
            end
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      fork
         monitorLoop();
      join_none

      reset       = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      mstatus_mie = 1'b0;
      mie_mask    = '0;
      csr_busy    = 1'b0;
      drain_ack   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_excep", excep, 32'h0);
      checkOutput("rst_ctrl", ctrlBits(), 32'h0);
      checkOutput("rst_cause", trap_cause, 32'h0);
      reset       = 1'b0;
      mstatus_mie = 1'b1;
      mie_mask    = 32'h80;
      tick();

      $display("[TB] timer path");
      sb.push_back(mkExp(1'b0, 32'h80000007, 1'b0));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("tp_excep_c1", excep, 32'h80);
      checkOutput("tp_ctrl_c1", ctrlBits(), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("tp_ctrl_c2_flush", ctrlBits(), 32'h30);
      tick();
      checkOutput("tp_ctrl_c3_drain", ctrlBits(), 32'h10);
      tick();
      checkOutput("tp_ctrl_c4_commit", ctrlBits(), 32'h18);
      checkOutput("tp_cause_c4", trap_cause, 32'h80000007);
      tick();
      checkOutput("tp_ctrl_c5_intrap", ctrlBits(), 32'h02);
      checkOutput("tp_excep_c5", excep, 32'h0);
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("tp_ctrl_mret_flush", ctrlBits(), 32'h32);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("tp_ctrl_mret_commit", ctrlBits(), 32'h06);
      tick();
      checkOutput("tp_ctrl_after_mret", ctrlBits(), 32'h00);

      $display("[TB] stray mret outside a trap");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mret_ignored", ctrlBits(), 32'h00);

      $display("[TB] priority");
      mie_mask = 32'h10880;
      sb.push_back(mkExp(1'b0, 32'h8000000B, 1'b0));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("pr_excep_all", excep, 32'h10880);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      checkOutput("pr_cause_ext", trap_cause, 32'h8000000B);
      tick();
      checkOutput("pr_excep_after_ext", excep, 32'h10080);
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      runMret();
      checkOutput("pr_ctrl_idle1", ctrlBits(), 32'h00);
      sb.push_back(mkExp(1'b0, 32'h80000010, 1'b0));
      tick();
      checkOutput("pr_ctrl_uart_flush", ctrlBits(), 32'h30);
      checkOutput("pr_cause_uart", trap_cause, 32'h80000010);
      repeat (3) tick();
      checkOutput("pr_excep_after_uart", excep, 32'h80);
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      runMret();
      sb.push_back(mkExp(1'b0, 32'h80000007, 1'b0));
      repeat (4) tick();
      checkOutput("pr_ctrl_timer_intrap", ctrlBits(), 32'h02);
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      runMret();
      checkOutput("pr_excep_empty", excep, 32'h0);

      $display("[TB] no nesting, mret then pending ext");
      sb.push_back(mkExp(1'b0, 32'h80000007, 1'b0));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("nest_ctrl_hold", ctrlBits(), 32'h02);
      checkOutput("nest_excep_ext", excep, 32'h800);
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("nest_ctrl_mret_flush", ctrlBits(), 32'h32);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("nest_ctrl_mret_commit", ctrlBits(), 32'h06);
      sb.push_back(mkExp(1'b0, 32'h8000000B, 1'b0));
      tick();
      checkOutput("nest_ctrl_idle", ctrlBits(), 32'h00);
      tick();
      checkOutput("nest_ctrl_ext_flush", ctrlBits(), 32'h30);
      checkOutput("nest_cause_ext", trap_cause, 32'h8000000B);
      repeat (3) tick();
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      runMret();

      $display("[TB] blocking by csr_busy and mstatus_mie");
      mie_mask = 32'h80;
      csr_busy = 1'b1;
      sb.push_back(mkExp(1'b0, 32'h80000007, 1'b0));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("blk_busy_ctrl", ctrlBits(), 32'h00);
      checkOutput("blk_busy_excep", excep, 32'h80);
      csr_busy    = 1'b0;
      mstatus_mie = 1'b0;
      tick();
      checkOutput("blk_mie_ctrl", ctrlBits(), 32'h00);
      mstatus_mie = 1'b1;
      tick();
      checkOutput("blk_release_flush", ctrlBits(), 32'h30);
      mstatus_mie = 1'b0;
      mie_mask    = 32'h0;
      repeat (3) tick();
      checkOutput("blk_masked_commit_done", ctrlBits(), 32'h02);
      mstatus_mie = 1'b1;
      mie_mask    = 32'h80;
      sb.push_back(mkExp(1'b1, 32'h0, 1'b0));
      runMret();

      $display("[TB] drain timeout");
      drain_ack = 1'b0;
      sb.push_back(mkExp(1'b0, 32'h80000007, 1'b1));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      repeat (DRAIN_TIMEOUT - 1) tick();
      checkOutput("to_ctrl_last_wait", ctrlBits(), 32'h10);
      tick();
      checkOutput("to_ctrl_commit", ctrlBits(), 32'h19);
      tick();
      checkOutput("to_ctrl_intrap_err", ctrlBits(), 32'h03);
      drain_ack = 1'b1;
      sb.push_back(mkExp(1'b1, 32'h0, 1'b1));
      runMret();
      checkOutput("to_err_sticky", ctrlBits(), 32'h01);

      $display("[TB] reset mid-sequence");
      drain_ack = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rm_ctrl_wait", ctrlBits(), 32'h11);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rm_ctrl_async", ctrlBits(), 32'h00);
      checkOutput("rm_excep_async", excep, 32'h0);
      checkOutput("rm_cause_async", trap_cause, 32'h0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      drain_ack = 1'b1;
      tick();
      checkOutput("rm_ctrl_after", ctrlBits(), 32'h00);
      checkOutput("rm_excep_after", excep, 32'h0);

      repeat (3) tick();
      checkOutput("sb_leftover", sb.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
               mismatched);
      $finish;
   end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Trap/interrupt sequencer sitting between the interrupt sources, the pipeline and the CSR register file. It latches timer, external and UART interrupt requests and drives them onto the CSR file's `excep` bus as pending bits. It arbitrates one winner, then sequences trap entry (flush, drain, commit) and MRET return. It also enforces a single, non-nested trap context.

Parameters:
- XLEN, 32, datapath width; matches CSR file width.
- DRAIN_TIMEOUT, 16, max cycles spent in WAIT_DRAIN before forced commit; legal range 2..255.

Ports:
- clk  input  1  system clock
- reset  input  1  reset is asynchronous and active-high
- timer_irq  input  1  timer interrupt request, level
- ext_irq  input  1  external interrupt request, level
- uart_irq  input  1  UART interrupt request, level
- mstatus_mie  input  1  global interrupt enable (mstatus[3] from CSR file)
- mie_mask  input  XLEN  mie contents; bits 7/11/16 used
- csr_busy  input  1  CSR instruction in flight; blocks trap start
- is_mret  input  1  MRET decoded at writeback
- drain_ack  input  1  pipeline reports drained
- excep  output  XLEN  pending bits to CSR file: [7]=timer, [11]=ext, [16]=uart, others 0
- flush_req  output  1  one-cycle pipeline flush request
- stall_fetch  output  1  hold fetch during sequencing
- trap_commit  output  1  one-cycle pulse; CSR file takes trap
- mret_commit  output  1  one-cycle pulse; CSR file returns to mepc
- trap_cause  output  XLEN  mcause encoding of current winner
- in_trap  output  1  trap context active
- drain_to_err  output  1  sticky; set on drain timeout

Behaviour:
- Reset (async, high): state IDLE; pending=0; counter=0; in_trap=0; drain_to_err=0. All outputs 0, trap_cause=0.
- Pending latch:
  - pending[k] sets at the clock edge where its irq is high.
  - pending[k] clears at the edge ending COMMIT for winner k.
  - Set and clear in the same cycle: set wins.
  - excep maps pending bits to [7]/[11]/[16].
- Eligible = pending & {mie_mask[16],mie_mask[11],mie_mask[7]} & mstatus_mie & !in_trap.
- Priority: ext > uart > timer.
- Winner is latched on the IDLE->FLUSH transition and held stable until IDLE.
- trap_cause encodings: ext = 0x8000000B, uart = 0x80000010, timer = 0x80000007.
- FSM states and transitions (registered); outputs decoded from state:
  - IDLE:
    - is_mret && in_trap -> MRET_FLUSH.
    - else eligible!=0 && !csr_busy -> FLUSH.
    - MRET has priority over a simultaneous eligible interrupt.
    - is_mret with !in_trap is ignored.
  - FLUSH: flush_req=1, stall_fetch=1; -> WAIT_DRAIN; counter cleared.
  - WAIT_DRAIN: stall_fetch=1; counter increments each cycle.
    - drain_ack -> COMMIT.
    - counter==DRAIN_TIMEOUT-1 without ack -> COMMIT, and drain_to_err sets.
  - COMMIT: trap_commit=1, stall_fetch=1; in_trap sets; -> IDLE.
  - MRET_FLUSH: flush_req=1, stall_fetch=1; -> MRET_COMMIT.
  - MRET_COMMIT: mret_commit=1; in_trap clears; -> IDLE.
- Latency: irq high sampled at edge 0 gives:
  - pending at cycle 1
  - FLUSH at cycle 2
  - WAIT_DRAIN at cycle 3
  - with drain_ack in cycle 3, trap_commit in cycle 4 (minimum 4 cycles)
- Source deasserts after pending is set: pending stays until committed (sticky).
- Masks dropping mid-sequence (FLUSH onward): the sequence completes; the latched winner is not re-evaluated.
- Reset asserted mid-sequence returns to IDLE immediately. No commit pulse is emitted.
- drain_to_err clears only on reset.

Optional Feature:
- CSR_IRQ_SYNC_EN defined:
  - Each irq input passes through a 2-flop synchronizer before the pending latch.
  - Minimum irq-to-trap_commit latency becomes 6 cycles.
- Undefined: irq inputs feed the pending latch directly (4-cycle minimum).

Test Plan:
- Timer path: mstatus_mie=1, mie_mask=0x80, pulse timer_irq 1 cycle, drain_ack high in WAIT_DRAIN -> excep=0x80 at cycle 1, flush_req at cycle 2, trap_commit at cycle 4, trap_cause=0x80000007, in_trap=1, excep=0 after.
- Priority: timer_irq, ext_irq, uart_irq all high together, mie_mask=0x10880 -> first trap_cause=0x8000000B. After MRET, uart next (0x80000010), then timer (0x80000007).
- Timeout: trap started, drain_ack held 0 -> trap_commit exactly DRAIN_TIMEOUT cycles after WAIT_DRAIN entry, drain_to_err=1 and stays 1.
- Nesting/MRET: in_trap=1, ext_irq high, is_mret pulsed in IDLE -> flush_req, then mret_commit next cycle, in_trap=0. The pending ext trap begins on the following cycle.
- Blocking: csr_busy=1 or mstatus_mie=0 with eligible timer -> FSM stays IDLE, excep[7]=1. Releasing the block -> FLUSH the next cycle.
- Reset mid-sequence: assert reset in WAIT_DRAIN -> all outputs 0 asynchronously, no trap_commit, state IDLE after release.
